// File: rtl/mvu_apb_bridge.sv
// mvu_apb_bridge: core valid/ready memory port to APB master bridge with address window and pready timeout
module mvu_apb_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [31:0] ADDR_MASK = 32'h0000_FFFF,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic [2:0]  pprot,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    input  logic        err_clr,
    output logic        err_slv,
    output logic        err_timeout
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t     state;
    logic [7:0] cnt;
    logic       hit, slv_set, to_set;
    assign hit     = mem_valid && ((mem_addr & ~ADDR_MASK) == BASE_ADDR);
    assign slv_set = (state == ACCESS) && pready && pslverr;
    assign to_set  = (state == ACCESS) && !pready && (cnt == 8'(TIMEOUT - 1));
    assign pprot   = 3'b000;
    // transfer sequencer with registered APB/core outputs; sticky error flags where a set beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= 32'd0;
            pwdata      <= 32'd0;
            pstrb       <= 4'd0;
            mem_ready   <= 1'b0;
            mem_rdata   <= 32'd0;
            err_slv     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_slv     <= slv_set | (err_slv & ~err_clr);
            err_timeout <= to_set | (err_timeout & ~err_clr);
            case (state)
                IDLE: if (hit) begin
                    state  <= SETUP;
                    psel   <= 1'b1;
                    paddr  <= mem_addr & ADDR_MASK;
                    pwrite <= |mem_wstrb;
                    pwdata <= mem_wdata;
                    pstrb  <= mem_wstrb;
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                    cnt     <= 8'd0;
                end
                ACCESS: begin
                    if (pready || to_set) begin
                        state     <= DONE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        mem_ready <= 1'b1;
                        mem_rdata <= pready ? prdata : 32'hDEAD_BEEF;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mvu_apb_bridge.sv
// tb_mvu_apb_bridge: vector table, directed corner sequences and randomized traffic against a memory-level model
module tb_mvu_apb_bridge;
    localparam int TIMEOUT = 16;
    typedef logic [31:0] mem_t [64];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ws;
        bit          serr;
        bit          hang;
        bit          hit;
        int          lat;
        bit          chk_rd;
        logic [31:0] rdata;
        bit          eslv;
        bit          eto;
    } vec_t;

    function automatic mem_t init_pat();
        mem_t m;
        for (int i = 0; i < 64; i++) m[i] = {16'hC0DE, 16'(i)};
        m[8] = 32'h1234_5678;
        return m;
    endfunction

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_valid = 1'b0, mem_ready, psel, penable, pwrite, pready, pslverr;
    logic        err_clr = 1'b0, err_slv, err_timeout;
    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata, paddr, pwdata, prdata;
    logic [3:0]  mem_wstrb = '0, pstrb;
    logic [2:0]  pprot;
    int          ws = 0;
    bit          serr = 1'b0, hang = 1'b0;
    int          acc_cnt;
    mem_t        smem = init_pat();
    mem_t        ref_mem = init_pat();
    int          checks = 0, errors = 0;
    bit          m_slv = 1'b0, m_to = 1'b0;

    mvu_apb_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .err_clr(err_clr),
        .err_slv(err_slv), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // APB slave: memory with programmable wait states, error response and hang
    assign pready  = psel && penable && !hang && (acc_cnt >= ws);
    assign pslverr = serr;
    assign prdata  = smem[paddr[7:2]];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt <= 0;
        else begin
            acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
            if (psel && penable && pready && pwrite && !pslverr)
                for (int b = 0; b < 4; b++)
                    if (pstrb[b]) smem[paddr[7:2]][8*b +: 8] <= pwdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model_write(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[7:2]][8*b +: 8] = w[8*b +: 8];
    endfunction

    task automatic do_req(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s, input int bound,
                          output bit got, output int lat, output logic [31:0] rd, output bit saw_psel);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = w; mem_wstrb = s;
        got = 1'b0; lat = 0; rd = '0; saw_psel = 1'b0;
        while (!got && lat < bound) begin
            @(posedge clk); #1;
            lat++;
            if (psel) saw_psel = 1'b1;
            if (mem_ready) begin got = 1'b1; rd = mem_rdata; end
        end
        if (got) begin
            @(posedge clk); #1;
            check("ready_one_cycle", {31'd0, mem_ready}, 32'd0);
        end
        mem_valid = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_slv = 1'b0; m_to = 1'b0;
        check("clr_slv", {31'd0, err_slv}, 32'd0);
        check("clr_to", {31'd0, err_timeout}, 32'd0);
    endtask

    vec_t        vecs[9];
    bit          got, saw;
    int          lat, exp_lat;
    logic [31:0] rd, a, w, up;
    logic [3:0]  s;
    bit          hit;

    initial begin
        vecs[0] = '{32'h4000_0010, 32'hA5A5_0001, 4'hF, 0, 0, 0, 1, 3, 0, 32'h0, 0, 0};
        vecs[1] = '{32'h4000_0020, 32'h0, 4'h0, 2, 0, 0, 1, 5, 1, 32'h1234_5678, 0, 0};
        vecs[2] = '{32'h8000_0000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0};
        vecs[3] = '{32'h4000_0010, 32'h0, 4'h0, 0, 0, 0, 1, 3, 1, 32'hA5A5_0001, 0, 0};
        vecs[4] = '{32'h4000_0030, 32'h0, 4'h0, 0, 0, 1, 1, 2 + TIMEOUT, 1, 32'hDEAD_BEEF, 0, 1};
        vecs[5] = '{32'h4000_0040, 32'hFFFF_1234, 4'h3, 0, 1, 0, 1, 3, 0, 32'h0, 1, 0};
        vecs[6] = '{32'h4000_0040, 32'h0, 4'h0, 1, 0, 0, 1, 4, 1, 32'hC0DE_0010, 0, 0};
        vecs[7] = '{32'h4000_FFFC, 32'hCAFE_F00D, 4'h8, 3, 0, 0, 1, 6, 0, 32'h0, 0, 0};
        vecs[8] = '{32'h4000_FFFC, 32'h0, 4'h0, 0, 0, 0, 1, 3, 1, 32'hCADE_003F, 0, 0};

        #3;
        check("rst_psel", {31'd0, psel}, 32'd0);
        check("rst_penable", {31'd0, penable}, 32'd0);
        check("rst_pwrite", {31'd0, pwrite}, 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_pstrb", {28'd0, pstrb}, 32'd0);
        check("rst_pprot", {29'd0, pprot}, 32'd0);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_errs", {30'd0, err_slv, err_timeout}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            ws = vecs[i].ws; serr = vecs[i].serr; hang = vecs[i].hang;
            do_req(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].hit ? 40 : 20, got, lat, rd, saw);
            check($sformatf("v%0d_ready", i), {31'd0, got}, {31'd0, vecs[i].hit});
            if (vecs[i].hit) check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            else check($sformatf("v%0d_psel", i), {31'd0, saw}, 32'd0);
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_err_slv", i), {31'd0, err_slv}, {31'd0, vecs[i].eslv});
            check($sformatf("v%0d_err_to", i), {31'd0, err_timeout}, {31'd0, vecs[i].eto});
            if (vecs[i].hit && !vecs[i].hang && !vecs[i].serr) model_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            serr = 1'b0; hang = 1'b0;
            clear_errs();
        end

        ws = 0;
        mem_valid = 1'b1; mem_addr = 32'h4000_0010; mem_wdata = 32'hA5A5_0001; mem_wstrb = 4'hF;
        @(posedge clk); #1;
        check("wr_setup_ctl", {29'd0, psel, penable, pwrite}, 32'b101);
        check("wr_setup_paddr", paddr, 32'h10);
        check("wr_setup_pstrb", {28'd0, pstrb}, 32'hF);
        check("wr_setup_pwdata", pwdata, 32'hA5A5_0001);
        @(posedge clk); #1;
        check("wr_access_ctl", {30'd0, psel, penable}, 32'b11);
        check("wr_access_paddr", paddr, 32'h10);
        @(posedge clk); #1;
        check("wr_done", {30'd0, mem_ready, psel}, 32'b10);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        model_write(32'h4000_0010, 32'hA5A5_0001, 4'hF);

        ws = 2;
        mem_valid = 1'b1; mem_addr = 32'h4000_0020; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        check("rd_setup_pwrite_pstrb", {27'd0, pwrite, pstrb}, 32'd0);
        lat = 1;
        while (!mem_ready && lat < 40) begin @(posedge clk); #1; lat++; end
        check("rd_latency", lat, 5);
        check("rd_rdata", mem_rdata, 32'h1234_5678);
        @(posedge clk); #1;
        mem_valid = 1'b0;

        ws = 0; serr = 1'b1;
        do_req(32'h4000_0044, 32'h1, 4'h1, 40, got, lat, rd, saw);
        check("slv_first", {31'd0, err_slv}, 32'd1);
        mem_valid = 1'b1; mem_addr = 32'h4000_0044; mem_wdata = 32'h2; mem_wstrb = 4'h1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("slv_set_beats_clr", {30'd0, err_slv, mem_ready}, 32'b11);
        @(posedge clk); #1;
        mem_valid = 1'b0; serr = 1'b0;
        clear_errs();

        hang = 1'b1;
        mem_valid = 1'b1; mem_addr = 32'h4000_0050; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_access", {30'd0, psel, penable}, 32'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctl", {29'd0, psel, penable, mem_ready}, 32'd0);
        mem_valid = 1'b0; hang = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(32'h4000_0050, 32'h5555_AAAA, 4'hF, 40, got, lat, rd, saw);
        check("post_reset_ready", {31'd0, got}, 32'd1);
        check("post_reset_latency", lat, 3);
        model_write(32'h4000_0050, 32'h5555_AAAA, 4'hF);

        for (int i = 0; i < 40; i++) begin
            hit = ($urandom_range(0, 9) != 0);
            up = {16'($urandom), 16'd0};
            if (up[31:16] == 16'h4000) up[31:16] = 16'h4001;
            a = hit ? {16'h4000, 8'($urandom), 6'($urandom), 2'b00} : (up | 32'($urandom_range(0, 16'hFFFF)));
            w = $urandom;
            s = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            ws = $urandom_range(0, 3);
            serr = ($urandom_range(0, 7) == 0);
            hang = ($urandom_range(0, 9) == 0);
            exp_lat = hang ? 2 + TIMEOUT : 3 + ws;
            do_req(a, w, s, hit ? 40 : 8, got, lat, rd, saw);
            check($sformatf("rnd%0d_ready", i), {31'd0, got}, {31'd0, hit});
            if (hit) begin
                check($sformatf("rnd%0d_latency", i), lat, exp_lat);
                if (s == 4'h0) check($sformatf("rnd%0d_rdata", i), rd, hang ? 32'hDEAD_BEEF : ref_mem[a[7:2]]);
                if (!hang && !serr) model_write(a, w, s);
                m_slv |= (!hang && serr);
                m_to |= hang;
            end else check($sformatf("rnd%0d_psel", i), {31'd0, saw}, 32'd0);
            check($sformatf("rnd%0d_errs", i), {30'd0, err_slv, err_timeout}, {30'd0, m_slv, m_to});
            serr = 1'b0; hang = 1'b0;
            if (i % 5 == 4) clear_errs();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
